// File: rtl/sm_output.sv
// sm_output: CPU-side transmit interface; buffers CPU words in a FIFO and hands
// packed flits to the router's local port over a 4-phase req/ack handshake.
module sm_output #(
  parameter logic [3:0] position      = 4'b0101,
  parameter int         DATA_WIDTH_EX = 37,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         FIFO_AW       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_data,
  input  logic [3:0]               cpu_dest,
  output logic                     cpu_ready,
  output logic                     Inr_L,
  input  logic                     Inw_L,
  output logic [DATA_WIDTH_EX-1:0] dataOutL,
  output logic [FIFO_AW:0]         fifo_level,
  output logic [15:0]              sent_count,
  output logic                     loopback
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [FIFO_AW-1:0] ptr_one = 1;
  localparam logic [FIFO_AW:0]   cnt_one = 1;
  localparam logic [FIFO_AW:0]   cnt_full = FIFO_DEPTH[FIFO_AW:0];
  logic [35:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   count;
  logic [1:0]         state;
  logic               push, pop;
  logic [35:0]        head;
  assign cpu_ready  = count != cnt_full;
  assign fifo_level = count;
  assign push       = cpu_we && cpu_ready;
  assign pop        = state == IDLE && count != '0 && !Inw_L;
  assign head       = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_data, cpu_dest};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop) rd_ptr <= rd_ptr + ptr_one;
      count <= (push && !pop) ? count + cnt_one : (!push && pop) ? count - cnt_one : count;
    end
  end
  // Handshake: load+request, wait ack high, drop request, wait ack low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      Inr_L      <= 1'b0;
      dataOutL   <= '0;
      loopback   <= 1'b0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          dataOutL <= {head[35:4], 1'b1, head[3:0]};
          loopback <= head[3:0] == position;
          Inr_L    <= 1'b1;
          state    <= REQ;
        end
        REQ: if (Inw_L) begin
          Inr_L <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: if (!Inw_L) begin
          sent_count <= sent_count + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_output.sv
// tb_sm_output: directed vectors plus hand-written sequences for sm_output.
module tb_sm_output;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_data;
  logic [3:0]  cpu_dest;
  logic        cpu_ready;
  logic        Inr_L;
  logic        Inw_L;
  logic [36:0] dataOutL;
  logic [2:0]  fifo_level;
  logic [15:0] sent_count;
  logic        loopback;
  int checks = 0;
  int errors = 0;

  sm_output dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_data(cpu_data),
    .cpu_dest(cpu_dest), .cpu_ready(cpu_ready), .Inr_L(Inr_L), .Inw_L(Inw_L),
    .dataOutL(dataOutL), .fifo_level(fifo_level), .sent_count(sent_count),
    .loopback(loopback)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] d;
    logic [3:0]  dst;
    logic        inw;
    logic        inr;
    logic [36:0] dout;
    logic [2:0]  lvl;
    logic        rdy;
    logic [15:0] sent;
    logic        loop;
  } vec_t;

  vec_t v [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [36:0] flit(input logic [31:0] d, input logic [3:0] dst);
    return {d, 1'b1, dst};
  endfunction

  task automatic write(input logic [31:0] d, input logic [3:0] dst);
    cpu_we = 1'b1; cpu_data = d; cpu_dest = dst;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!Inr_L && n < 10) begin tick(); n++; end
    chk(name, 64'(Inr_L), 64'd1);
  endtask

  initial begin
    reset = 1'b0; cpu_we = 1'b0; cpu_data = '0; cpu_dest = '0; Inw_L = 1'b0;
    #3;
    chk("rst_inr", 64'(Inr_L), 0);
    chk("rst_dout", 64'(dataOutL), 0);
    chk("rst_ready", 64'(cpu_ready), 1);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_sent", 64'(sent_count), 0);
    chk("rst_loop", 64'(loopback), 0);
    reset = 1'b1;
    tick();

    v[0]  = '{1'b1, 32'hDEADBEEF, 4'b1001, 1'b0, 1'b0, 37'h0,          3'd1, 1'b1, 16'd0, 1'b0};
    v[1]  = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 37'h1BD5B7DDF9, 3'd0, 1'b1, 16'd0, 1'b0};
    v[2]  = '{1'b0, 32'h0,        4'h0,    1'b1, 1'b0, 37'h1BD5B7DDF9, 3'd0, 1'b1, 16'd0, 1'b0};
    v[3]  = '{1'b0, 32'h0,        4'h0,    1'b1, 1'b0, 37'h1BD5B7DDF9, 3'd0, 1'b1, 16'd0, 1'b0};
    v[4]  = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b0, 37'h1BD5B7DDF9, 3'd0, 1'b1, 16'd1, 1'b0};
    v[5]  = '{1'b1, 32'h11,       4'b0101, 1'b0, 1'b0, 37'h1BD5B7DDF9, 3'd1, 1'b1, 16'd1, 1'b0};
    v[6]  = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b1, flit(32'h11, 4'b0101), 3'd0, 1'b1, 16'd1, 1'b1};
    v[7]  = '{1'b0, 32'h0,        4'h0,    1'b1, 1'b0, flit(32'h11, 4'b0101), 3'd0, 1'b1, 16'd1, 1'b1};
    v[8]  = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b0, flit(32'h11, 4'b0101), 3'd0, 1'b1, 16'd2, 1'b1};
    v[9]  = '{1'b1, 32'h22,       4'b0110, 1'b0, 1'b0, flit(32'h11, 4'b0101), 3'd1, 1'b1, 16'd2, 1'b1};
    v[10] = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b1, flit(32'h22, 4'b0110), 3'd0, 1'b1, 16'd2, 1'b0};
    v[11] = '{1'b0, 32'h0,        4'h0,    1'b1, 1'b0, flit(32'h22, 4'b0110), 3'd0, 1'b1, 16'd2, 1'b0};
    v[12] = '{1'b0, 32'h0,        4'h0,    1'b0, 1'b0, flit(32'h22, 4'b0110), 3'd0, 1'b1, 16'd3, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cpu_we = v[i].we; cpu_data = v[i].d; cpu_dest = v[i].dst; Inw_L = v[i].inw;
      tick();
      chk($sformatf("v%0d_inr", i), 64'(Inr_L), 64'(v[i].inr));
      chk($sformatf("v%0d_dout", i), 64'(dataOutL), 64'(v[i].dout));
      chk($sformatf("v%0d_level", i), 64'(fifo_level), 64'(v[i].lvl));
      chk($sformatf("v%0d_ready", i), 64'(cpu_ready), 64'(v[i].rdy));
      chk($sformatf("v%0d_sent", i), 64'(sent_count), 64'(v[i].sent));
      chk($sformatf("v%0d_loop", i), 64'(loopback), 64'(v[i].loop));
    end
    cpu_we = 1'b0; Inw_L = 1'b0;

    // Fill the FIFO while the first flit waits for an acknowledge.
    do_reset();
    for (int k = 1; k <= 5; k++) write(32'(k), 4'h3);
    chk("full_level", 64'(fifo_level), 4);
    chk("full_ready", 64'(cpu_ready), 0);
    write(32'd6, 4'h3);
    chk("drop_level", 64'(fifo_level), 4);
    for (int k = 1; k <= 5; k++) begin
      wait_req($sformatf("order%0d_req", k));
      chk($sformatf("order%0d_data", k), 64'(dataOutL[36:5]), 64'(k));
      Inw_L = 1'b1;
      tick();
      chk($sformatf("order%0d_drop", k), 64'(Inr_L), 0);
      Inw_L = 1'b0;
      tick();
    end
    chk("order_sent", 64'(sent_count), 5);
    chk("order_level", 64'(fifo_level), 0);
    tick();
    chk("order_no_sixth", 64'(Inr_L), 0);

    // Stale acknowledge blocks a new request.
    Inw_L = 1'b1;
    write(32'h33, 4'h2);
    tick(); tick();
    chk("stale_inr", 64'(Inr_L), 0);
    chk("stale_level", 64'(fifo_level), 1);
    Inw_L = 1'b0;
    tick();
    chk("stale_release_inr", 64'(Inr_L), 1);
    chk("stale_release_dout", 64'(dataOutL), 64'(flit(32'h33, 4'h2)));
    Inw_L = 1'b1; tick();
    Inw_L = 1'b0; tick();
    chk("stale_sent", 64'(sent_count), 6);

    // Reset during REQ with two words still buffered.
    write(32'h41, 4'h1);
    write(32'h42, 4'h1);
    write(32'h43, 4'h1);
    chk("mid_inr", 64'(Inr_L), 1);
    chk("mid_level", 64'(fifo_level), 2);
    reset = 1'b0;
    #2;
    chk("mid_rst_inr", 64'(Inr_L), 0);
    chk("mid_rst_dout", 64'(dataOutL), 0);
    chk("mid_rst_ready", 64'(cpu_ready), 1);
    chk("mid_rst_level", 64'(fifo_level), 0);
    chk("mid_rst_sent", 64'(sent_count), 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Inw_L = i[0];
      tick();
      chk($sformatf("post_rst_inr%0d", i), 64'(Inr_L), 0);
    end
    chk("post_rst_level", 64'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
